// File: rtl/conv_buffer_ctrl_pkg.sv
// Shared types and defaults for the convolution row-set buffer controller.
package conv_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } ctrl_state_t;

    localparam int DEF_BUFFER_SIZE = 8;
    localparam int DEF_KERNEL_SIZE = 9;
    localparam int DEF_ROW_W       = 16;

    // Side length of a square kernel; 0 when taps is not a perfect square.
    function automatic int kdim_of(input int taps);
        int r;
        r = 0;
        for (int i = 1; i * i <= taps; i++) begin
            if (i * i == taps) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_buffer_ctrl_wrap_ptr.sv
// Buffer slot pointer that wraps modulo DEPTH, with clear and load.
module wrap_ptr
    import conv_buf_pkg::*;
#(
    parameter int DEPTH = DEF_BUFFER_SIZE,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             ld,
    input  logic [PTR_W-1:0] ld_val,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (ld) begin
            ptr_d = ld_val;
        end else if (inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/conv_buffer_ctrl.sv
// Row-set buffer sequencer: accepts rows from the loader, presents
// KDIM-row sliding windows to the MAC array and tracks occupancy.
module conv_buffer_ctrl
    import conv_buf_pkg::*;
#(
    parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int ROW_W       = DEF_ROW_W,
    parameter int PTR_W       = $clog2(BUFFER_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [ROW_W-1:0] cfg_rows,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             buf_wen,
    output logic [PTR_W-1:0] buf_waddr,
    output logic [PTR_W-1:0] buf_raddr,
    output logic             mac_valid,
    input  logic             mac_ready,
    output logic [ROW_W-1:0] mac_row,
    output logic [PTR_W:0]   occupancy
);

    localparam int KDIM = kdim_of(KERNEL_SIZE);
    localparam logic [ROW_W-1:0] KDIM_ROW = ROW_W'(KDIM);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(BUFFER_SIZE);
    localparam logic [PTR_W:0]   OCC_WIN  = (PTR_W + 1)'(KDIM);

    ctrl_state_t state_q, state_d;

    logic [ROW_W-1:0] cfg_rows_q, cfg_rows_d;
    logic [ROW_W-1:0] rows_in_q, rows_in_d;
    logic [ROW_W-1:0] mac_row_q, mac_row_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             cfg_err_q, cfg_err_d;

    logic [PTR_W-1:0] wptr, rptr;
    logic             run, wr, rd;
    logic             ptr_clr, rptr_ld;

    assign run       = (state_q == RUN);
    assign src_ready = run && (occ_q < OCC_FULL) && (rows_in_q < cfg_rows_q);
    assign mac_valid = run && (occ_q >= OCC_WIN);
    assign wr        = src_valid && src_ready;
    assign rd        = mac_valid && mac_ready;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN);
    assign cfg_err   = cfg_err_q;
    assign buf_wen   = wr;
    assign buf_waddr = wptr;
    assign buf_raddr = rptr;
    assign mac_row   = mac_row_q;
    assign occupancy = occ_q;

    always_comb begin
        state_d    = state_q;
        cfg_rows_d = cfg_rows_q;
        rows_in_d  = rows_in_q;
        mac_row_d  = mac_row_q;
        occ_d      = occ_q;
        cfg_err_d  = 1'b0;
        ptr_clr    = 1'b0;
        rptr_ld    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_rows >= KDIM_ROW) begin
                        state_d    = RUN;
                        cfg_rows_d = cfg_rows;
                        rows_in_d  = '0;
                        mac_row_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (wr) rows_in_d = rows_in_q + 1'b1;
                if (rd) mac_row_d = mac_row_q + 1'b1;
                unique case ({wr, rd})
                    2'b10:   occ_d = occ_q + 1'b1;
                    2'b01:   occ_d = occ_q - 1'b1;
                    default: occ_d = occ_q;
                endcase
                if (rd && (mac_row_q == cfg_rows_q - KDIM_ROW)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last KDIM-1 rows are never reused by this job.
                occ_d   = '0;
                rptr_ld = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d   = IDLE;
            rows_in_d = '0;
            mac_row_d = '0;
            occ_d     = '0;
            cfg_err_d = 1'b0;
            ptr_clr   = 1'b1;
            rptr_ld   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_rows_q <= '0;
            rows_in_q  <= '0;
            mac_row_q  <= '0;
            occ_q      <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_rows_q <= cfg_rows_d;
            rows_in_q  <= rows_in_d;
            mac_row_q  <= mac_row_d;
            occ_q      <= occ_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    wrap_ptr #(
        .DEPTH (BUFFER_SIZE),
        .PTR_W (PTR_W)
    ) u_wptr (
        .clk    (clk),
        .rst    (rst),
        .inc    (wr),
        .clr    (ptr_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .ptr    (wptr)
    );

    wrap_ptr #(
        .DEPTH (BUFFER_SIZE),
        .PTR_W (PTR_W)
    ) u_rptr (
        .clk    (clk),
        .rst    (rst),
        .inc    (rd),
        .clr    (ptr_clr),
        .ld     (rptr_ld),
        .ld_val (wptr),
        .ptr    (rptr)
    );

    assert property (@(posedge clk) disable iff (rst) occ_q <= OCC_FULL);
    assert property (@(posedge clk) disable iff (rst)
        !(wr && !rd && occ_q == OCC_FULL));
    assert property (@(posedge clk) disable iff (rst)
        !(rd && !wr && occ_q == '0));

endmodule

// File: tb/tb_conv_buffer_ctrl.sv
// Randomised bench for conv_buffer_ctrl against a counter/array model
// of the row-set buffer, plus directed job scenarios.
module tb_conv_buffer_ctrl;

    localparam int BS = 8;
    localparam int K  = 3;
    localparam int RW = 16;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, src_valid, mac_ready;
    logic [RW-1:0] cfg_rows;
    logic          busy, done, cfg_err, src_ready, buf_wen, mac_valid;
    logic [PW-1:0] buf_waddr, buf_raddr;
    logic [RW-1:0] mac_row;
    logic [PW:0]   occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: absolute write/read counts; slots are counts mod BS.
    bit m_active, m_drain, m_err;
    int m_rows, m_in, m_out, m_wcnt, m_rcnt;
    int tbmem [BS];

    always #5 clk = ~clk;

    conv_buffer_ctrl #(
        .BUFFER_SIZE (BS),
        .KERNEL_SIZE (K * K),
        .ROW_W       (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_rows  (cfg_rows),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .buf_wen   (buf_wen),
        .buf_waddr (buf_waddr),
        .buf_raddr (buf_raddr),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .mac_row   (mac_row),
        .occupancy (occupancy)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit pct(int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic bit e_src_ready();
        return m_active && (m_wcnt - m_rcnt) < BS && m_in < m_rows;
    endfunction

    function automatic bit e_mac_valid();
        return m_active && (m_wcnt - m_rcnt) >= K;
    endfunction

    task automatic model_clear();
        m_active = 0;
        m_drain  = 0;
        m_err    = 0;
        m_in     = 0;
        m_out    = 0;
        m_wcnt   = 0;
        m_rcnt   = 0;
    endtask

    task automatic cycle();
        bit wr, rd;
        @(negedge clk);
        wr = e_src_ready() && src_valid;
        rd = e_mac_valid() && mac_ready;
        chk("busy", busy, m_active || m_drain);
        chk("done", done, m_drain);
        chk("cfg_err", cfg_err, m_err);
        chk("src_ready", src_ready, e_src_ready());
        chk("buf_wen", buf_wen, wr);
        chk("waddr", buf_waddr, m_wcnt % BS);
        chk("mac_valid", mac_valid, e_mac_valid());
        chk("raddr", buf_raddr, m_rcnt % BS);
        chk("mac_row", mac_row, m_out);
        chk("occupancy", occupancy, m_wcnt - m_rcnt);
        if (rd && !abort) begin
            for (int i = 0; i < K; i++)
                chk("window", tbmem[(int'(buf_raddr) + i) % BS], m_out + i);
        end
        if (buf_wen) tbmem[buf_waddr] = m_in;

        m_err = 0;
        if (abort) begin
            model_clear();
        end else if (m_drain) begin
            m_drain = 0;
            m_rcnt  = m_wcnt;
        end else if (m_active) begin
            if (rd) begin
                m_rcnt++;
                m_out++;
                if (m_out == m_rows - K + 1) begin
                    m_active = 0;
                    m_drain  = 1;
                end
            end
            if (wr) begin
                m_wcnt++;
                m_in++;
            end
        end else if (start) begin
            if (int'(cfg_rows) >= K) begin
                m_active = 1;
                m_rows   = cfg_rows;
                m_in     = 0;
                m_out    = 0;
            end else begin
                m_err = 1;
            end
        end
        @(posedge clk);
        #1;
        start = 0;
        abort = 0;
    endtask

    task automatic finish_job(int pv, int pr, int ab, bit noise);
        int c;
        c = 0;
        while ((m_active || m_drain) && c < 3000) begin
            src_valid = pct(pv);
            mac_ready = pct(pr);
            abort     = ($urandom_range(999) < ab);
            if (noise && $urandom_range(19) == 0) begin
                start    = 1;
                cfg_rows = RW'($urandom_range(20));
            end
            cycle();
            c++;
        end
        chk("job_timeout", m_active || m_drain, 0);
    endtask

    task automatic run_job(int rows, int pv, int pr, int ab, bit noise);
        start     = 1;
        cfg_rows  = RW'(rows);
        src_valid = pct(pv);
        mac_ready = pct(pr);
        cycle();
        finish_job(pv, pr, ab, noise);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            src_valid = pct(50);
            mac_ready = pct(50);
            cycle();
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst       = 1;
        start     = 0;
        abort     = 0;
        src_valid = 0;
        mac_ready = 0;
        cfg_rows  = '0;
        model_clear();
        for (int i = 0; i < BS; i++) tbmem[i] = -1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_mac_valid", mac_valid, 0);
        chk("rst_occ", occupancy, 0);
        @(posedge clk);
        #1;
        rst = 0;
        idle(2);

        // Basic job at full rate.
        run_job(5, 100, 100, 0, 0);
        idle(2);

        // Backpressure until full, then release the MAC side.
        start     = 1;
        cfg_rows  = 10;
        src_valid = 1;
        mac_ready = 0;
        cycle();
        for (int i = 0; i < 12; i++) cycle();
        chk("full_occ", occupancy, 8);
        chk("full_ready", src_ready, 0);
        finish_job(100, 100, 0, 0);
        idle(1);

        // Wrap-around job with steady write+consume overlap.
        start     = 1;
        cfg_rows  = 20;
        src_valid = 1;
        mac_ready = 1;
        cycle();
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i >= 2) chk("steady_occ", occupancy, 3);
        end
        finish_job(100, 100, 0, 0);
        run_job(12, 100, 100, 0, 0);

        // Rejected configuration.
        start    = 1;
        cfg_rows = 2;
        cycle();
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        idle(2);

        // Abort after the window for mac_row 1, then a clean job.
        start     = 1;
        cfg_rows  = 12;
        src_valid = 1;
        mac_ready = 1;
        cycle();
        for (int c = 0; c < 50 && m_out < 2; c++) cycle();
        abort = 1;
        cycle();
        chk("abort_busy", busy, 0);
        chk("abort_occ", occupancy, 0);
        idle(2);
        run_job(6, 100, 100, 0, 0);

        // Asynchronous reset in the middle of a job.
        start     = 1;
        cfg_rows  = 15;
        src_valid = 1;
        mac_ready = 1;
        cycle();
        for (int i = 0; i < 6; i++) cycle();
        #2;
        rst = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_src_ready", src_ready, 0);
        chk("arst_mac_valid", mac_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_mac_row", mac_row, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
        run_job(7, 100, 100, 0, 0);

        // Random jobs with stray starts and rare aborts.
        for (int j = 0; j < 30; j++) begin
            run_job($urandom_range(20), 20 + $urandom_range(80),
                    20 + $urandom_range(80), 3, 1);
            idle(1 + $urandom_range(2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
